// File: rtl/execute_pkg.sv
// Shared EX-stage definitions: ALU opcodes, forwarding select, multiplier FSM states.
package execute_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MUL   = 4'b1000;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {FWD_REG, FWD_EXMEM, FWD_MEMWB} fwd_sel_t;
  typedef enum logic [1:0] {EX_IDLE, EX_BUSY, EX_DONE} ex_state_t;

  // The younger producer (EX/MEM) takes priority; XZR is never a forwarding source.
  function automatic fwd_sel_t fwd_select(input logic [4:0] rs,
                                          input logic [4:0] ex_rd, input logic ex_we,
                                          input logic [4:0] wb_rd, input logic wb_we);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (ex_we && ex_rd != XZR && ex_rd == rs)
      sel = FWD_EXMEM;
    else if (wb_we && wb_rd != XZR && wb_rd == rs)
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/execute_mc_iter_mul.sv
// Iterative MUL_K-bits-per-cycle multiplier with IDLE/BUSY/DONE control; latency N/MUL_K+1.
// Holds the pipeline via stall_E while busy; flush_E abandons the operation with no result.
module iter_mul #(
  parameter int N     = 64,
  parameter int MUL_K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic         is_mul,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic [N-1:0] acc_q,
  output logic         result_sel,
  output logic         stall_E,
  output logic         done_E
);
  import execute_pkg::*;

  localparam int STEPS = N / MUL_K;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  ex_state_t        state_q, state_d;
  logic [N-1:0]     opa_q, opb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     partial;
  logic [31:0]      shamt;
  logic             start;
  logic             last_step;
  logic             stall_c, done_c;

  assign start   = valid_E & is_mul & ~flush_E;
  assign partial = opa_q * N'(opb_q[MUL_K-1:0]);
  assign shamt   = 32'(cnt_q) * 32'(MUL_K);

`ifdef MUL_EARLY_EXIT_EN
  // Remaining multiplier digits all zero: the accumulator already holds the product.
  assign last_step = (cnt_q == LAST) || (opb_q == '0);
`else
  assign last_step = (cnt_q == LAST);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EX_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        EX_IDLE: if (start) begin
          opa_q <= op_a;
          opb_q <= op_b;
          acc_q <= '0;
          cnt_q <= '0;
        end
        EX_BUSY: begin
          acc_q <= acc_q + (partial << shamt);
          opb_q <= opb_q >> MUL_K;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    done_c     = 1'b0;
    result_sel = 1'b0;
    case (state_q)
      EX_IDLE: begin
        if (start) begin
          state_d = EX_BUSY;
          stall_c = 1'b1;
        end else begin
          done_c = valid_E & ~is_mul & ~flush_E;
        end
      end
      EX_BUSY: begin
        if (flush_E) begin
          state_d = EX_IDLE;
        end else begin
          stall_c = 1'b1;
          if (last_step) state_d = EX_DONE;
        end
      end
      EX_DONE: begin
        // ID/EX still shows the finished MUL this cycle; never re-issue it.
        state_d    = EX_IDLE;
        result_sel = 1'b1;
        done_c     = ~flush_E;
      end
      default: state_d = EX_IDLE;
    endcase
  end

  // Handshake outputs are forced quiet while reset is held.
  assign stall_E = reset & stall_c;
  assign done_E  = reset & done_c;

endmodule

// File: rtl/execute_mc.sv
// LEGv8 EX stage: forwarding, branch target, 1-cycle ALU ops, iterative MUL (N/MUL_K+1 cycles).
// stall_E holds upstream during MUL; MUL_EARLY_EXIT_EN ends MUL once remaining multiplier is 0.
module execute_mc #(
  parameter int N     = 64,
  parameter int MUL_K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic         AluSrc,
  input  logic         mov,
  input  logic [3:0]   AluControl,
  input  logic [4:0]   ID_EXRegRn,
  input  logic [4:0]   ID_EXRegRm,
  input  logic [4:0]   EX_MEMRegRd,
  input  logic [4:0]   MEM_WBRegRd,
  input  logic         EX_MEMregWrite,
  input  logic         MEM_WBregWrite,
  input  logic [N-1:0] EX_MEMResult,
  input  logic [N-1:0] memoryResult,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E,
  output logic         stall_E,
  output logic         done_E
);
  import execute_pkg::*;

  if (N % MUL_K != 0) begin : g_param_check
    $error("execute_mc: N must be a multiple of MUL_K");
  end

  fwd_sel_t     sel_a, sel_b;
  logic [N-1:0] fwd_a, fwd_b;
  logic [N-1:0] alu_a, alu_b, alu_y;
  logic [N-1:0] mul_acc;
  logic         mul_sel;
  logic         is_mul;

  assign sel_a = fwd_select(ID_EXRegRn, EX_MEMRegRd, EX_MEMregWrite, MEM_WBRegRd, MEM_WBregWrite);
  assign sel_b = fwd_select(ID_EXRegRm, EX_MEMRegRd, EX_MEMregWrite, MEM_WBRegRd, MEM_WBregWrite);

  always_comb begin
    fwd_a = readData1_E;
    case (sel_a)
      FWD_EXMEM: fwd_a = EX_MEMResult;
      FWD_MEMWB: fwd_a = memoryResult;
      default:   fwd_a = readData1_E;
    endcase
  end

  always_comb begin
    fwd_b = readData2_E;
    case (sel_b)
      FWD_EXMEM: fwd_b = EX_MEMResult;
      FWD_MEMWB: fwd_b = memoryResult;
      default:   fwd_b = readData2_E;
    endcase
  end

  assign alu_a       = mov ? signImm_E : fwd_a;
  assign alu_b       = AluSrc ? signImm_E : fwd_b;
  assign writeData_E = fwd_b;
  assign PCBranch_E  = PC_E + (signImm_E << 2);
  assign is_mul      = (AluControl == ALU_MUL);

  always_comb begin
    alu_y = '0;
    case (AluControl)
      ALU_AND:   alu_y = alu_a & alu_b;
      ALU_OR:    alu_y = alu_a | alu_b;
      ALU_ADD:   alu_y = alu_a + alu_b;
      ALU_SUB:   alu_y = alu_a - alu_b;
      ALU_PASSB: alu_y = alu_b;
      ALU_NOR:   alu_y = ~(alu_a | alu_b);
      default:   alu_y = '0;
    endcase
  end

  iter_mul #(.N(N), .MUL_K(MUL_K)) u_iter_mul (
    .clk        (clk),
    .reset      (reset),
    .valid_E    (valid_E),
    .flush_E    (flush_E),
    .is_mul     (is_mul),
    .op_a       (alu_a),
    .op_b       (alu_b),
    .acc_q      (mul_acc),
    .result_sel (mul_sel),
    .stall_E    (stall_E),
    .done_E     (done_E)
  );

  assign aluResult_E = mul_sel ? mul_acc : alu_y;
  assign zero_E      = (aluResult_E == '0);

endmodule

// File: tb/tb_execute_mc.sv
// Randomized self-checking bench for execute_mc (N=64, MUL_K=4) against a behavioural model.
module tb_execute_mc;
  import execute_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_E, flush_E, AluSrc, mov;
  logic [3:0]  AluControl;
  logic [4:0]  ID_EXRegRn, ID_EXRegRm, EX_MEMRegRd, MEM_WBRegRd;
  logic        EX_MEMregWrite, MEM_WBregWrite;
  logic [63:0] EX_MEMResult, memoryResult, PC_E, signImm_E, readData1_E, readData2_E;
  logic [63:0] PCBranch_E, aluResult_E, writeData_E;
  logic        zero_E, stall_E, done_E;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  execute_mc #(.N(64), .MUL_K(4)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .flush_E(flush_E),
    .AluSrc(AluSrc), .mov(mov), .AluControl(AluControl),
    .ID_EXRegRn(ID_EXRegRn), .ID_EXRegRm(ID_EXRegRm),
    .EX_MEMRegRd(EX_MEMRegRd), .MEM_WBRegRd(MEM_WBRegRd),
    .EX_MEMregWrite(EX_MEMregWrite), .MEM_WBregWrite(MEM_WBregWrite),
    .EX_MEMResult(EX_MEMResult), .memoryResult(memoryResult),
    .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E), .readData2_E(readData2_E),
    .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
    .zero_E(zero_E), .stall_E(stall_E), .done_E(done_E)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_operand(input logic [4:0] rs, input logic [63:0] reg_val);
    if (EX_MEMregWrite && EX_MEMRegRd == rs && EX_MEMRegRd != 5'd31) return EX_MEMResult;
    if (MEM_WBregWrite && MEM_WBRegRd == rs && MEM_WBRegRd != 5'd31) return memoryResult;
    return reg_val;
  endfunction

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    case (op)
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_PASSB: return b;
      ALU_NOR:   return ~(a | b);
      default:   return 64'd0;
    endcase
  endfunction

  // Issue-to-done cycles; early exit ends once all unconsumed multiplier digits are zero.
  function automatic int ref_mul_latency(input logic [63:0] b);
`ifdef MUL_EARLY_EXIT_EN
    for (int k = 0; k < 16; k++)
      if ((b >> (4 * k)) == 64'd0) return k + 2;
`endif
    return 17;
  endfunction

  task automatic clear_inputs();
    valid_E = 0; flush_E = 0; AluSrc = 0; mov = 0; AluControl = ALU_ADD;
    ID_EXRegRn = 0; ID_EXRegRm = 0; EX_MEMRegRd = 0; MEM_WBRegRd = 0;
    EX_MEMregWrite = 0; MEM_WBregWrite = 0;
    EX_MEMResult = 0; memoryResult = 0; PC_E = 0; signImm_E = 0;
    readData1_E = 0; readData2_E = 0;
  endtask

  task automatic drive_add(input logic [63:0] a, input logic [63:0] b);
    clear_inputs();
    valid_E = 1; AluControl = ALU_ADD; ID_EXRegRn = 1; ID_EXRegRm = 2;
    readData1_E = a; readData2_E = b;
  endtask

  // Issues one MUL, holds it until done, then presents a bubble to confirm no re-issue.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input string name);
    logic [63:0] exp_p, res;
    int          exp_lat, lat;
    logic        got, stall_bad, z;
    exp_p = a * b;
    exp_lat = ref_mul_latency(b);
    clear_inputs();
    valid_E = 1; AluControl = ALU_MUL; ID_EXRegRn = 1; ID_EXRegRm = 2;
    readData1_E = a; readData2_E = b;
    got = 0; stall_bad = 0; lat = -1; res = '0; z = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (done_E === 1'b1) begin
        got = 1; lat = c; res = aluResult_E; z = zero_E;
        if (stall_E !== 1'b0) stall_bad = 1;
      end else if (stall_E !== 1'b1) begin
        stall_bad = 1;
      end
      @(negedge clk);
      readData1_E = ~a;
      readData2_E = ~b;
    end
    n_checks++;
    if (lat !== exp_lat) $display("FAIL %s_latency got %0d exp %0d", name, lat, exp_lat);
    else n_pass++;
    n_checks++;
    if (res !== exp_p) $display("FAIL %s_result got %h exp %h", name, res, exp_p);
    else n_pass++;
    n_checks++;
    if (z !== (exp_p == 64'd0)) $display("FAIL %s_zero got %b exp %b", name, z, exp_p == 64'd0);
    else n_pass++;
    n_checks++;
    if (stall_bad !== 1'b0) $display("FAIL %s_stall_profile got bad=%b exp bad=0", name, stall_bad);
    else n_pass++;
    clear_inputs();
    #1;
    n_checks++;
    if ({stall_E, done_E} !== 2'b00)
      $display("FAIL %s_no_restart got stall/done=%b%b exp 00", name, stall_E, done_E);
    else n_pass++;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 0;
    @(negedge clk);
    valid_E = 1; AluControl = ALU_MUL; readData1_E = 64'd6; readData2_E = 64'd7;
    PC_E = 64'h100; signImm_E = 64'd4;
    #1;
    n_checks++;
    if ({stall_E, done_E} !== 2'b00)
      $display("FAIL reset_handshake got stall/done=%b%b exp 00", stall_E, done_E);
    else n_pass++;
    n_checks++;
    if (PCBranch_E !== 64'h110) $display("FAIL reset_pcbranch got %h exp %h", PCBranch_E, 64'h110);
    else n_pass++;
    @(negedge clk);
    clear_inputs();
    reset = 1;
    #1;
    n_checks++;
    if ({stall_E, done_E} !== 2'b00)
      $display("FAIL reset_release_bubble got stall/done=%b%b exp 00", stall_E, done_E);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_add();
    drive_add(64'd5, 64'd7);
    #1;
    n_checks++;
    if ({aluResult_E, done_E, stall_E, zero_E} !== {64'd12, 1'b1, 1'b0, 1'b0})
      $display("FAIL add_5_7 got res=%0d done=%b stall=%b zero=%b exp res=12 done=1 stall=0 zero=0",
               aluResult_E, done_E, stall_E, zero_E);
    else n_pass++;
    @(negedge clk);
    drive_add(64'd7, 64'd7);
    AluControl = ALU_SUB;
    #1;
    n_checks++;
    if ({aluResult_E, zero_E} !== {64'd0, 1'b1})
      $display("FAIL sub_zero got res=%h zero=%b exp res=0 zero=1", aluResult_E, zero_E);
    else n_pass++;
    @(negedge clk);
    drive_add(64'd1, 64'd2);
    flush_E = 1;
    #1;
    n_checks++;
    if (done_E !== 1'b0) $display("FAIL flush_idle_done got %b exp 0", done_E);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    logic [4:0]  regs [4];
    logic [3:0]  ops [6];
    logic [63:0] a, b, exp_y;
    regs = '{5'd0, 5'd1, 5'd2, 5'd31};
    ops  = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB, ALU_NOR};
    drive_add(64'd100, 64'd1);
    ID_EXRegRn = 3; ID_EXRegRm = 4;
    EX_MEMRegRd = 3; EX_MEMregWrite = 1; EX_MEMResult = 64'd9;
    MEM_WBRegRd = 3; MEM_WBregWrite = 1; memoryResult = 64'd3;
    #1;
    n_checks++;
    if (aluResult_E !== 64'd10) $display("FAIL fwd_exmem_priority got %0d exp 10", aluResult_E);
    else n_pass++;
    @(negedge clk);
    ID_EXRegRn = 31; EX_MEMRegRd = 31; MEM_WBRegRd = 31;
    #1;
    n_checks++;
    if (aluResult_E !== 64'd101) $display("FAIL fwd_xzr_blocked got %0d exp 101", aluResult_E);
    else n_pass++;
    @(negedge clk);
    ID_EXRegRm = 5; MEM_WBRegRd = 5; memoryResult = 64'hABCD;
    #1;
    n_checks++;
    if (writeData_E !== 64'hABCD) $display("FAIL fwd_writedata got %h exp %h", writeData_E, 64'hABCD);
    else n_pass++;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      clear_inputs();
      valid_E        = 1;
      AluControl     = ops[$urandom_range(0, 5)];
      AluSrc         = ($urandom_range(0, 3) == 0);
      mov            = ($urandom_range(0, 7) == 0);
      ID_EXRegRn     = regs[$urandom_range(0, 3)];
      ID_EXRegRm     = regs[$urandom_range(0, 3)];
      EX_MEMRegRd    = regs[$urandom_range(0, 3)];
      MEM_WBRegRd    = regs[$urandom_range(0, 3)];
      EX_MEMregWrite = $urandom_range(0, 1);
      MEM_WBregWrite = $urandom_range(0, 1);
      EX_MEMResult   = {$urandom, $urandom};
      memoryResult   = {$urandom, $urandom};
      readData1_E    = {$urandom, $urandom};
      readData2_E    = {$urandom, $urandom};
      PC_E           = {$urandom, $urandom};
      signImm_E      = {$urandom, $urandom};
      a = mov ? signImm_E : ref_operand(ID_EXRegRn, readData1_E);
      b = AluSrc ? signImm_E : ref_operand(ID_EXRegRm, readData2_E);
      exp_y = ref_alu(AluControl, a, b);
      #1;
      n_checks++;
      if ({aluResult_E, zero_E, done_E, stall_E} !== {exp_y, exp_y == 64'd0, 1'b1, 1'b0})
        $display("FAIL rand_alu[%0d] got res=%h z=%b d=%b s=%b exp res=%h z=%b d=1 s=0",
                 i, aluResult_E, zero_E, done_E, stall_E, exp_y, exp_y == 64'd0);
      else n_pass++;
      n_checks++;
      if (writeData_E !== ref_operand(ID_EXRegRm, readData2_E))
        $display("FAIL rand_wdata[%0d] got %h exp %h", i, writeData_E,
                 ref_operand(ID_EXRegRm, readData2_E));
      else n_pass++;
      n_checks++;
      if (PCBranch_E !== PC_E + (signImm_E << 2))
        $display("FAIL rand_pcbranch[%0d] got %h exp %h", i, PCBranch_E, PC_E + (signImm_E << 2));
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    logic [63:0] a, b;
    run_mul(64'h1234, 64'h10, "mul_1234x10");
    run_mul(64'h8000_0000_0000_0000, 64'd2, "mul_wrap");
    run_mul(64'hDEAD_BEEF, 64'd0, "mul_by_zero");
    for (int i = 0; i < 4; i++) begin
      a = {$urandom, $urandom};
      b = (i % 2 == 0) ? {$urandom, $urandom} : 64'($urandom_range(1, 4095));
      run_mul(a, b, $sformatf("mul_rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    run_mul(64'd11, 64'd13, "b2b_first");
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "b2b_second");
    drive_add(64'd20, 64'd22);
    #1;
    n_checks++;
    if ({aluResult_E, done_E} !== {64'd42, 1'b1})
      $display("FAIL b2b_add got res=%0d done=%b exp res=42 done=1", aluResult_E, done_E);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_flush_busy();
    logic seen;
    clear_inputs();
    valid_E = 1; AluControl = ALU_MUL; readData1_E = 64'h55; readData2_E = 64'hFFFF_0000_0000_0001;
    for (int c = 0; c < 5; c++) @(negedge clk);
    flush_E = 1;
    #1;
    n_checks++;
    if ({stall_E, done_E} !== 2'b00)
      $display("FAIL flush_busy_same_cycle got stall/done=%b%b exp 00", stall_E, done_E);
    else n_pass++;
    @(negedge clk);
    clear_inputs();
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall_E !== 1'b0 || done_E !== 1'b0) seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL flush_busy_quiet got activity=%b exp 0", seen);
    else n_pass++;
    drive_add(64'd5, 64'd7);
    #1;
    n_checks++;
    if ({aluResult_E, done_E, stall_E} !== {64'd12, 1'b1, 1'b0})
      $display("FAIL flush_then_add got res=%0d done=%b stall=%b exp 12 1 0",
               aluResult_E, done_E, stall_E);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    clear_inputs();
    valid_E = 1; AluControl = ALU_MUL; readData1_E = 64'h77; readData2_E = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 8; c++) @(negedge clk);
    reset = 0;
    #1;
    n_checks++;
    if ({stall_E, done_E} !== 2'b00)
      $display("FAIL reset_mid_mul got stall/done=%b%b exp 00", stall_E, done_E);
    else n_pass++;
    @(negedge clk);
    reset = 1;
    run_mul(64'd3, 64'd3, "mul_after_reset");
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_add();
    test_forwarding();
    test_mul();
    test_back_to_back();
    test_flush_busy();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
